// File: rtl/mux_add_pipe.sv
// Add/pass selector feeding a DEPTH-entry registered result buffer with valid/ready on both sides.
// Define MUX_ADD_PIPE_SAT_EN to saturate overflowing sums to all-ones instead of wrapping.
module mux_add_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           w,
    output logic                       c,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             c;
        logic [WIDTH-1:0] w;
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    logic   [PW-1:0]    rd_ptr, wr_ptr;
    logic   [CW-1:0]    cnt;
    logic   [WIDTH:0]   sum;
    entry_t             res;
    logic               push, pop;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res = '0;
        if (s) begin
            res.w = b;
        end else begin
            res.c = sum[WIDTH];
`ifdef MUX_ADD_PIPE_SAT_EN
            res.w = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
            res.w = sum[WIDTH-1:0];
`endif
        end
    end

    // Flags come only from the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (cnt < CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    assign w     = mem[rd_ptr].w;
    assign c     = mem[rd_ptr].c;
    assign count = cnt;
endmodule

// File: tb/tb_mux_add_pipe.sv
// Directed bench for mux_add_pipe: reset, sum/pass/overflow, back-pressure, streaming, mid-run reset.
module tb_mux_add_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             s = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] w;
    logic             c;
    logic [1:0]       count;

    int total = 0;
    int bad   = 0;

    mux_add_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .w(w), .c(c), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit later, then new inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (w !== 8'h00) begin bad++; $display("FAIL reset_w got=%h want=00", w); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL reset_c got=%0b want=0", c); end
    endtask

    task automatic test_single_sum();
        a = 8'h12; b = 8'h34; s = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sum_out_valid got=%0b want=1", out_valid); end
        total++; if (w !== 8'h46) begin bad++; $display("FAIL sum_w got=%h want=46", w); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL sum_c got=%0b want=0", c); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL sum_count1 got=%0d want=1", count); end
        cyc();
        total++; if (count !== 2'd0) begin bad++; $display("FAIL sum_count0 got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sum_drained got=%0b want=0", out_valid); end
    endtask

    task automatic test_pass_overflow();
        logic [7:0] exp_w;
`ifdef MUX_ADD_PIPE_SAT_EN
        exp_w = 8'hFF;
`else
        exp_w = 8'h10;
`endif
        out_ready = 1'b0;
        a = 8'hFF; b = 8'h07; s = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (w !== 8'h07) begin bad++; $display("FAIL pass_w got=%h want=07", w); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL pass_c got=%0b want=0", c); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        a = 8'hF0; b = 8'h20; s = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (c !== 1'b1) begin bad++; $display("FAIL ovf_c got=%0b want=1", c); end
        total++; if (w !== exp_w) begin bad++; $display("FAIL ovf_w got=%h want=%h", w, exp_w); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL ovf_drain got=%0d want=0", count); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        a = 8'h01; b = 8'h02; s = 1'b0; in_valid = 1'b1;
        cyc();
        a = 8'h10; b = 8'h20; s = 1'b0;
        cyc();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_count_full got=%0d want=2", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%0b want=0", in_ready); end
        a = 8'hAA; b = 8'h55; s = 1'b1;
        cyc();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_third_held got=%0d want=2", count); end
        total++; if (w !== 8'h03) begin bad++; $display("FAIL bp_head_stable got=%h want=03", w); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (count !== 2'd1) begin bad++; $display("FAIL bp_after_pop got=%0d want=1", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_rise got=%0b want=1", in_ready); end
        total++; if (w !== 8'h30) begin bad++; $display("FAIL bp_second got=%h want=30", w); end
        cyc();
        in_valid = 1'b0;
        total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_third_accepted got=%0d want=2", count); end
        out_ready = 1'b1;
        cyc();
        total++; if (w !== 8'h55) begin bad++; $display("FAIL bp_third_order got=%h want=55", w); end
        cyc();
        out_ready = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL bp_drained got=%0d want=0", count); end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_w;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 8'(i); b = 8'(2 * i); s = i[0]; in_valid = 1'b1;
            exp_w = i[0] ? 8'(2 * i) : 8'(3 * i);
            cyc();
            total++;
            if (out_valid !== 1'b1 || w !== exp_w || c !== 1'b0 || count !== 2'd1) begin
                bad++;
                $display("FAIL stream_%0d got v=%0b w=%h c=%0b n=%0d want v=1 w=%h c=0 n=1",
                         i, out_valid, w, c, count, exp_w);
            end
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d want=0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        a = 8'h11; b = 8'h22; s = 1'b0; in_valid = 1'b1;
        cyc(); cyc();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL rm_prefill got=%0d want=2", count); end
        rst = 1'b1; out_ready = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%0b want=1", in_ready); end
        total++; if (w !== 8'h00) begin bad++; $display("FAIL rm_w got=%h want=00", w); end
        cyc();
        total++; if (count !== 2'd0) begin bad++; $display("FAIL rm_idle got=%0d want=0", count); end
    endtask

    initial begin
        test_reset();
        test_single_sum();
        test_pass_overflow();
        test_back_pressure();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_add_pipe.md
Name: mux_add_pipe

Overview:
- Parametrised, pipelined successor to the single-bit add/pass selector.
- Per transaction, selects between operand B (s=1) and sum A+B (s=0) on WIDTH-bit operands. Carry is reported.
- Results sit in a registered 2-entry output buffer with valid/ready handshakes on both sides, so the block drops into streaming datapaths with back-pressure.

Parameters:
- WIDTH, 8, operand and result data width in bits (>=1).
- DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  1  select: 1 = pass b, 0 = a+b.
- out_valid  out  1  buffer head holds a result.
- out_ready  in  1  downstream accepts the head this cycle.
- w  out  WIDTH  result data.
- c  out  1  carry of a+b; 0 when s=1.
- count  out  $clog2(DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset: rst sampled high on a rising edge.
  - Clears read pointer, write pointer and count to 0.
  - Outputs: out_valid=0, in_ready=1, count=0.
  - w and c read 0 while empty, because buffer storage is cleared.
  - Reset mid-operation discards all buffered results. No output handshake completes in the reset cycle.
- Push: occurs when in_valid && in_ready.
  - Result is computed combinationally: {c,w} = s ? {1'b0,b} : a+b, evaluated at WIDTH+1 bits.
  - Result and carry are written at the write pointer on the clock edge.
- Pop: occurs when out_valid && out_ready. The read pointer advances.
- Flag derivation:
  - in_ready = (count < DEPTH), derived from registered count only. No combinational path from out_ready.
  - out_valid = (count != 0).
  - w and c are driven from the entry at the read pointer.
- Latency: a result accepted on edge N is visible on w/c with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one transaction per cycle while downstream holds out_ready=1.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0, in_valid is ignored, a/b/s are not sampled. A pop in this cycle frees a slot; in_ready rises the following cycle.
- Empty (count=0):
  - A pop cannot occur.
  - out_ready is ignored.
  - There is no combinational bypass: the push lands first, and data appears the next cycle.
- Pointers wrap modulo DEPTH.
- Count is never below 0 or above DEPTH.
- Holding rules:
  - Head data stays stable while out_valid=1 and out_ready=0.
  - Upstream must hold a/b/s stable while in_valid=1 and in_ready=0.
- Arithmetic: unsigned only. Sum wraps at 2^WIDTH; the overflow bit is reported on c.

Optional Feature:
- Macro: MUX_ADD_PIPE_SAT_EN.
- Defined: when s=0 and a+b >= 2^WIDTH, the stored w is all-ones (saturated) and c=1. The s=1 path is unchanged.
- Undefined: w holds the low WIDTH bits of the sum (wrap-around) and c=1 flags the overflow.
- Storage, handshake and latency are identical in both builds.

Test Plan:
1. Reset then idle, WIDTH=8:
   - rst=1 for 2 cycles -> out_valid=0, in_ready=1, count=0, w=0, c=0.
2. Single sum:
   - Push a=8'h12, b=8'h34, s=0 with out_ready=1 -> next cycle out_valid=1, w=8'h46, c=0.
   - Following cycle: count=0.
3. Pass and overflow:
   - Push s=1, a=8'hFF, b=8'h07 -> w=8'h07, c=0.
   - Push s=0, a=8'hF0, b=8'h20 -> c=1; w=8'h10 without the macro, w=8'hFF with MUX_ADD_PIPE_SAT_EN.
4. Back-pressure:
   - Hold out_ready=0 and push 3 transactions -> first two accepted, count=2, in_ready=0, third held.
   - Raise out_ready=1 for one cycle -> head popped; in_ready=1 next cycle; third accepted; order preserved.
5. Streaming:
   - in_valid=1 and out_ready=1 for 16 cycles with a=i, b=2i, s=i[0] -> 16 results in order, one per cycle after 1-cycle latency, count constant at 1.
6. Reset mid-operation:
   - With count=2, assert rst for 1 cycle while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; no pop or push counted in the reset cycle.
